window_buffer: RTL and testbench

WINDOW_BUFFER -- requirements
Module: window_buffer

---
 rtl/window_buffer_pkg.sv | 7 +
 rtl/window_buffer_line_buffer.sv | 26 ++
 rtl/window_buffer.sv | 96 +++++++++
 tb/tb_window_buffer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/window_buffer_pkg.sv
// Shared definitions for the window buffer slice.
package window_buffer_pkg;

    // Pixel width used across the image pipeline.
    localparam int WORD_SIZE = 8;

endpackage

// File: rtl/window_buffer_line_buffer.sv
// Fixed-length row delay line: q presents the value written DEPTH enables ago.
module line_buffer #(
    parameter int DEPTH     = 640,
    parameter int WORD_SIZE = window_buffer_pkg::WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [WORD_SIZE-1:0] d,
    output logic [WORD_SIZE-1:0] q
);

    logic [WORD_SIZE-1:0] sr [DEPTH];

    // Shift one position per enabled cycle; no reset so it maps to SRL/RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/window_buffer.sv
// 3x3 sliding window generator over a raster pixel stream.
module window_buffer
    import window_buffer_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic [WORD_SIZE-1:0] p1,
    output logic [WORD_SIZE-1:0] p2,
    output logic [WORD_SIZE-1:0] p3,
    output logic [WORD_SIZE-1:0] p4,
    output logic [WORD_SIZE-1:0] p5,
    output logic [WORD_SIZE-1:0] p6,
    output logic [WORD_SIZE-1:0] p7,
    output logic [WORD_SIZE-1:0] p8,
    output logic [WORD_SIZE-1:0] p9,
    output logic                 out_valid,
    output logic                 frame_done
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic                 accept;
    logic                 x_last;
    logic                 y_last;
    logic [WORD_SIZE-1:0] row1_q;
    logic [WORD_SIZE-1:0] row2_q;

    // Pixels offered while in reset are dropped, including from the delay lines.
    assign accept = in_valid && reset_n;
    assign x_last = (x == XW'(IMG_WIDTH - 1));
    assign y_last = (y == YW'(IMG_HEIGHT - 1));

    line_buffer #(.DEPTH(IMG_WIDTH), .WORD_SIZE(WORD_SIZE)) u_row1 (
        .clk (clk),
        .en  (accept),
        .d   (in_data),
        .q   (row1_q)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WORD_SIZE(WORD_SIZE)) u_row2 (
        .clk (clk),
        .en  (accept),
        .d   (row1_q),
        .q   (row2_q)
    );

    // Raster position of the next pixel plus the per-accept status flags.
    // Validity keys off the position so stale line contents after reset or a
    // frame wrap are never flagged.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x          <= '0;
            y          <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= in_valid && (x >= XW'(2)) && (y >= YW'(2));
            frame_done <= in_valid && x_last && y_last;
            if (in_valid) begin
                if (x_last) begin
                    x <= '0;
                    y <= y_last ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

    // Window shifts left on each accept; the new right column comes from the
    // two row delays (oldest row on top) and the live pixel.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            {p1, p2, p3, p4, p5, p6, p7, p8, p9} <= '0;
        end else if (in_valid) begin
            p1 <= p2;
            p2 <= p3;
            p3 <= row2_q;
            p4 <= p5;
            p5 <= p6;
            p6 <= row1_q;
            p7 <= p8;
            p8 <= p9;
            p9 <= in_data;
        end
    end

endmodule

// File: tb/tb_window_buffer.sv
module tb_window_buffer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic [W-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic         out_valid;
    logic         frame_done;

    window_buffer #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .p4         (p4),
        .p5         (p5),
        .p6         (p6),
        .p7         (p7),
        .p8         (p8),
        .p9         (p9),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int fd_seen = 0;

    logic [9*W-1:0] exp_q [$];
    logic [9*W-1:0] last_win = '0;
    logic [9*W-1:0] cur_win;
    logic           drv_last = 1'b0;
    logic           acc_q = 1'b0;
    logic           rst_q = 1'b1;
    logic           fd_exp = 1'b0;

    // Hand-computed windows of a 4x4 frame of pixels 0..15, in output order.
    logic [W-1:0] tbl [4][9];
    initial begin
        tbl[0] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        tbl[1] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        tbl[2] = '{4, 5, 6, 8, 9, 10, 12, 13, 14};
        tbl[3] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    end

    assign cur_win = {p1, p2, p3, p4, p5, p6, p7, p8, p9};

    always @(posedge clk) begin
        acc_q  <= in_valid && reset_n;
        rst_q  <= reset_n;
        fd_exp <= in_valid && reset_n && drv_last;
    end

    // Monitor: checks away from the active edge.
    always @(negedge clk) begin
        logic [9*W-1:0] e;
        total <= total + 1;
        if (frame_done !== fd_exp) begin
            bad <= bad + 1;
            $display("FAIL frame_done: got %b want %b at %0t", frame_done, fd_exp, $time);
        end
        if (frame_done === 1'b1) fd_seen <= fd_seen + 1;
        if (!rst_q) begin
            if (cur_win !== '0 || out_valid !== 1'b0) begin
                bad <= bad + 1;
                $display("FAIL reset_state: win=%h vld=%b want 0/0", cur_win, out_valid);
            end
        end else if (!acc_q) begin
            if (out_valid !== 1'b0 || cur_win !== last_win) begin
                bad <= bad + 1;
                $display("FAIL gap_hold: win=%h vld=%b want %h vld=0", cur_win, out_valid, last_win);
            end
        end else if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                bad <= bad + 1;
                $display("FAIL unexpected_window: got %h, none expected", cur_win);
            end else begin
                e = exp_q.pop_front();
                if (cur_win !== e) begin
                    bad <= bad + 1;
                    $display("FAIL window: got %h want %h", cur_win, e);
                end
            end
        end
        last_win <= cur_win;
    end

    task automatic cycle(input logic v, input logic [W-1:0] d, input logic last);
        in_valid = v;
        in_data  = d;
        drv_last = last;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int base, input int count, input bit gaps);
        logic [9*W-1:0] w;
        int k;
        for (int i = 0; i < count; i++) begin
            if ((i % 4) >= 2 && (i / 4) >= 2) begin
                k = (i / 4 - 2) * 2 + (i % 4 - 2);
                for (int j = 0; j < 9; j++) w[(8-j)*W +: W] = tbl[k][j] + W'(base);
                exp_q.push_back(w);
            end
            cycle(1'b1, W'(base + i), i == 15);
            if (gaps) cycle(1'b0, 8'hEE, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk); #1;
        cycle(1'b1, 8'h55, 1'b0);           // in_valid during reset is ignored
        reset_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);

        send_frame(0, 16, 1'b0);            // continuous frame
        cycle(1'b0, 8'h00, 1'b0);
        send_frame(0, 16, 1'b1);            // alternating valid/idle
        send_frame(0, 16, 1'b0);            // back-to-back frames
        send_frame(100, 16, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);

        send_frame(0, 10, 1'b0);            // partial frame, then reset
        reset_n = 1'b0;
        cycle(1'b1, 8'h77, 1'b0);
        reset_n = 1'b1;
        send_frame(0, 16, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);

        total = total + 2;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL missing_windows: %0d left, want 0", exp_q.size());
        end
        if (fd_seen != 5) begin
            bad = bad + 1;
            $display("FAIL frame_done_count: got %0d want 5", fd_seen);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
